// File: rtl/online_result_collector.sv
// online_result_collector: sink for an MSD-first radix-2 signed-digit stream.
// After start it drops DELTA leading digits, then runs on-the-fly conversion of
// N digits into an (N+1)-bit two's-complement word and pulses valid for one cycle.
module online_result_collector #(
    parameter int N     = 16,
    parameter int DELTA = 3,
    parameter int CW    = 5
) (
    input  logic         clk,
    input  logic         asyn_reset,
    input  logic         enable,
    input  logic         start,
    input  logic [1:0]   digit_in,
    output logic [N:0]   result,
    output logic         valid,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter values marking the last skipped digit and the last converted digit.
    localparam logic [CW-1:0] SKIP_LAST = CW'((DELTA > 0) ? (DELTA - 1) : 0);
    localparam logic [CW-1:0] CONV_LAST = CW'(N - 1);

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         counter;
    logic signed [N:0]     q;
    logic signed [N:0]     qm;
    logic [2*N+1:0]        step;
    logic [N:0]            q_next;
    logic [N:0]            qm_next;
    logic                  skip_last;
    logic                  conv_last;

    // One on-the-fly conversion step. QM tracks Q-1 so that a -1 digit never
    // needs a borrow chain: the new Q is taken from the shifted QM instead.
    // Encodings 00 and 11 both mean zero.
    function automatic logic [2*N+1:0] otf_step(
        input logic [N:0] q_cur,
        input logic [N:0] qm_cur,
        input logic [1:0] d
    );
        logic [2*N+1:0] r;
        case (d)
            2'b10:   r = {q_cur[N-1:0],  1'b1, q_cur[N-1:0],  1'b0};
            2'b01:   r = {qm_cur[N-1:0], 1'b1, qm_cur[N-1:0], 1'b0};
            default: r = {q_cur[N-1:0],  1'b0, qm_cur[N-1:0], 1'b1};
        endcase
        return r;
    endfunction

    assign step      = otf_step(q, qm, digit_in);
    assign q_next    = step[2*N+1:N+1];
    assign qm_next   = step[N:0];
    assign skip_last = (counter == SKIP_LAST);
    assign conv_last = (counter == CONV_LAST);
    assign busy      = (state != IDLE);

    // State register; holds while enable is low.
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, so starts while busy or in DONE are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (DELTA > 0) ? SKIP : CONV;
                end
            end
            SKIP: begin
                if (skip_last) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Digit counter, Q/QM conversion registers, result capture and valid pulse.
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            counter <= '0;
            q       <= '0;
            qm      <= '1;
            result  <= '0;
            valid   <= 1'b0;
        end else if (enable) begin
            valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        counter <= '0;
                        q       <= '0;
                        qm      <= '1;
                    end
                end
                SKIP: begin
                    counter <= skip_last ? '0 : counter + CW'(1);
                end
                CONV: begin
                    q  <= q_next;
                    qm <= qm_next;
                    if (conv_last) begin
                        counter <= '0;
                        result  <= q_next;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_online_result_collector.sv
// Self-checking bench for online_result_collector (DELTA=3 and DELTA=0 builds).
module tb_online_result_collector;

    localparam int N     = 16;
    localparam int DELTA = 3;
    localparam int CW    = 5;

    logic         clk = 1'b0;
    logic         asyn_reset;
    logic         enable;
    logic         start;
    logic [1:0]   digit_in;
    logic [N:0]   result;
    logic         valid;
    logic         busy;

    logic         z_enable;
    logic         z_start;
    logic [1:0]   z_digit;
    logic [N:0]   z_result;
    logic         z_valid;
    logic         z_busy;

    int           checks = 0;
    int           passed = 0;
    int           fails  = 0;
    logic [1:0]   digs [N];
    logic [N:0]   last_exp;

    online_result_collector #(.N(N), .DELTA(DELTA), .CW(CW)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .enable     (enable),
        .start      (start),
        .digit_in   (digit_in),
        .result     (result),
        .valid      (valid),
        .busy       (busy)
    );

    online_result_collector #(.N(N), .DELTA(0), .CW(CW)) dut_z (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .enable     (z_enable),
        .start      (z_start),
        .digit_in   (z_digit),
        .result     (z_result),
        .valid      (z_valid),
        .busy       (z_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value of a signed digit: +1, -1 or 0.
    function automatic int dval(input logic [1:0] d);
        if (d == 2'b10) return 1;
        if (d == 2'b01) return -1;
        return 0;
    endfunction

    // Reference: sum of d_i * 2^(N-i), truncated to N+1 bits (two's complement).
    function automatic logic [N:0] model();
        int s;
        logic [31:0] w;
        s = 0;
        for (int i = 0; i < N; i++) s = s * 2 + dval(digs[i]);
        w = s;
        return w[N:0];
    endfunction

    task automatic fill(input logic [1:0] first, input logic [1:0] rest);
        digs[0] = first;
        for (int i = 1; i < N; i++) digs[i] = rest;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) digs[i] = 2'($urandom);
    endtask

    // One complete conversion on the DELTA=3 instance with cycle-exact expectations.
    task automatic run(input string tag, input logic [N:0] exp, input int stall_at,
                       input int stall_len, input bit pulse_start, input bit done_stall);
        logic early;
        early    = 1'b0;
        enable   = 1'b1;
        start    = 1'b1;
        digit_in = 2'($urandom);
        tick();
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_result_hold_on_start"}, 32'(result), 32'(last_exp));
        for (int k = 0; k < DELTA; k++) begin
            digit_in = 2'($urandom);
            tick();
            early |= valid;
        end
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    enable   = 1'b0;
                    digit_in = 2'($urandom);
                    tick();
                    early |= valid;
                end
            end
            enable   = 1'b1;
            start    = pulse_start;
            digit_in = digs[i];
            tick();
            if (i < N - 1) early |= valid;
        end
        start = 1'b0;
        check({tag, "_no_early_valid"}, 32'(early), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        if (done_stall) begin
            enable   = 1'b0;
            digit_in = 2'($urandom);
            tick();
            tick();
            check({tag, "_valid_held_in_stall"}, 32'(valid), 32'd1);
            enable = 1'b1;
        end
        start = pulse_start;
        tick();
        start = 1'b0;
        check({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
        check({tag, "_busy_falls"}, 32'(busy), 32'd0);
        check({tag, "_result_holds"}, 32'(result), 32'(exp));
        tick();
        check({tag, "_no_restart"}, 32'(busy | valid), 32'd0);
        last_exp = exp;
    endtask

    initial begin
        logic       seen;
        logic [N:0] e;
        asyn_reset = 1'b0;
        enable     = 1'b1;
        start      = 1'b0;
        digit_in   = 2'b00;
        z_enable   = 1'b1;
        z_start    = 1'b0;
        z_digit    = 2'b00;
        last_exp   = '0;
        #12;
        check("reset_result", 32'(result), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        tick();
        #3 asyn_reset = 1'b1;
        tick();
        tick();
        check("idle_after_reset", 32'({busy, valid}), 32'd0);

        fill(2'b10, 2'b10);
        run("all_plus", 17'h0FFFF, -1, 0, 1'b0, 1'b0);
        fill(2'b01, 2'b01);
        run("all_minus", 17'h10001, -1, 0, 1'b0, 1'b0);
        fill(2'b10, 2'b01);
        run("plus_then_minus", 17'h00001, -1, 0, 1'b0, 1'b0);
        fill(2'b10, 2'b11);
        run("plus_then_11", 17'h08000, -1, 0, 1'b0, 1'b0);
        fill(2'b10, 2'b10);
        run("stall", 17'h0FFFF, 8, 5, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            e = model();
            run($sformatf("random%0d", r), e, (r == 2) ? 5 : -1, 3, r[0], 1'b0);
        end

        // Asynchronous reset in the middle of a conversion.
        fill(2'b10, 2'b10);
        enable = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < DELTA + 10; k++) begin
            digit_in = digs[0];
            tick();
        end
        #3 asyn_reset = 1'b0;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        last_exp = '0;
        tick();
        #3 asyn_reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < N + DELTA + 4; k++) begin
            digit_in = 2'b10;
            tick();
            seen |= valid | busy;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run("after_abort", 17'h0FFFF, -1, 0, 1'b0, 1'b0);

        fill_random();
        e = model();
        run("start_while_busy", e, -1, 0, 1'b1, 1'b1);

        // DELTA=0 build: the digit present at the first edge after start is converted.
        for (int r = 0; r < 2; r++) begin
            fill_random();
            e       = model();
            seen    = 1'b0;
            z_start = 1'b1;
            tick();
            z_start = 1'b0;
            check($sformatf("d0_busy%0d", r), 32'(z_busy), 32'd1);
            for (int i = 0; i < N; i++) begin
                z_digit = digs[i];
                tick();
                if (i < N - 1) seen |= z_valid;
            end
            check($sformatf("d0_no_early_valid%0d", r), 32'(seen), 32'd0);
            check($sformatf("d0_valid%0d", r), 32'(z_valid), 32'd1);
            check($sformatf("d0_result%0d", r), 32'(z_result), 32'(e));
            tick();
            check($sformatf("d0_done%0d", r), 32'({z_valid, z_busy}), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/online_result_collector.md
Name: online_result_collector

Overview:
- Receiving end of the MSD-first radix-2 signed-digit (online) serial stream that feeds the Newton datapath.
- Consumes the 2-bit digit stream produced by an online unit, such as the Newton iteration output.
- Discards the first DELTA digits (online delay), then converts N digits on the fly into a two's-complement word.
- Flags completion with a one-cycle valid pulse. Used as the output stage of the Newton datapath and as a self-checking sink in benches.

Parameters:
- N, 16: number of result digits converted.
- DELTA, 3: online delay; leading digits discarded after start. 0 is legal.
- CW, 5: width of the internal digit counter. Must hold max(N, DELTA).

Ports:
- clk  input  1  rising-edge clock.
- asyn_reset  input  1  asynchronous, active-low reset. 0 resets immediately.
- enable  input  1  clock-enable/stall. While 0: state, counter, Q, QM and outputs hold; digit_in is ignored.
- start  input  1  begin a conversion. Sampled only in IDLE with enable=1.
- digit_in  input  2  signed digit; value = digit_in[1] - digit_in[0]. 01 = -1, 10 = +1, 00 = 0, 11 = 0.
- result  output  N+1  two's-complement integer sum of d_i*2^(N-i), i = 1..N. Real value is result*2^-N.
- valid  output  1  one-cycle pulse when result is updated.
- busy  output  1  high in SKIP, CONV and DONE.

Behaviour:
- Reset values: result=0, valid=0, busy=0, state=IDLE, counter=0, Q=0, QM=all ones.
- All transitions below occur on rising clk edges with enable=1. With enable=0 nothing changes, including valid.
- IDLE:
  - start=1 -> Q=0, QM=-1 (all ones), counter=0.
  - Go to SKIP if DELTA>0, else CONV.
  - start=0 -> stay in IDLE.
- SKIP:
  - Each edge consumes and discards digit_in; counter++.
  - At counter==DELTA-1, clear counter and go to CONV.
- CONV: each edge consumes digit d and shifts left by one (width N+1) using on-the-fly conversion:
  - d=+1: Q <= {Q,1}, QM <= {Q,0}.
  - d=0: Q <= {Q,0}, QM <= {QM,1}.
  - d=-1: Q <= {QM,1}, QM <= {QM,0}.
  - Invariant: QM == Q-1 at all times.
  - counter++. On the Nth digit (counter==N-1), result <= next Q (the value including this digit); go to DONE.
- DONE: valid=1 for this cycle (registered); return to IDLE on the next enabled edge.
- Latency: start accepted at edge 0 -> DELTA skip edges -> N conversion edges.
  - Final digit consumed at edge DELTA+N.
  - valid high for the cycle following edge DELTA+N.
  - A stall extends this latency by the number of enable=0 cycles.
- result holds its value from one completion until the next completion or reset. It does not change on start.
- start while busy: ignored. No restart, no error flag.
- start in DONE: ignored. A new start is accepted only once back in IDLE.
- Overflow: impossible. |result| <= 2^N-1 and QM >= -2^N, both fit N+1 bits.
- Reset mid-operation: immediate return to reset values. No valid pulse for the aborted conversion.
- Encoding 11 is treated as 0 with no flag.

Test Plan:
- N=16, DELTA=3; start, 3 arbitrary skip digits, then 16 x 10 (+1) -> valid exactly one cycle after edge 19; result=17'h0FFFF; busy falls one cycle after valid rises.
- 16 x 01 (-1) -> result=17'h10001 (-65535).
- Digits +1 then 15 x -1 (exercises the QM path) -> result=17'h00001. Also +1 followed by 15 x 11 -> result=17'h08000.
- Same +1 stream with enable=0 for 5 cycles at digit 8 (digit_in driven to garbage during the stall) -> result=17'h0FFFF; valid 5 cycles later than the unstalled run.
- asyn_reset=0 asserted asynchronously (between edges) after digit 10 -> result=0, busy=0 immediately, no valid. A fresh run then yields the correct 17'h0FFFF.
- start pulsed during CONV and during DONE -> no restart; exactly one valid. DELTA=0 build: first digit after start is converted; valid after edge N.
